// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand-select stage and its hazard-unit users.
package fwd_pkg;

   localparam logic MODE_EXPLICIT = 1'b0;
   localparam logic MODE_PRIORITY = 1'b1;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CNT_W = 8;

   // Bit offset of source idx inside a flattened {src[N-1], ..., src[0]} bus.
   function automatic int slice_off(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/fwd_sel_stage_if.sv
// Operand-select bundle: ID-side request and hazard controls in, registered operand out.
interface fwd_sel_stage_if
   import fwd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N_SRC = 4,
   parameter int CNT_W = DEFAULT_CNT_W
);
   localparam int SEL_W = $clog2(N_SRC);

   logic                   in_valid;
   logic                   mode;
   logic [SEL_W-1:0]       sel;
   logic [N_SRC*WIDTH-1:0] src_data;
   logic [N_SRC-1:0]       src_hit;
   logic [N_SRC-1:0]       src_ready;
   logic                   stall_in;
   logic                   flush;
   logic                   stall_req;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic [SEL_W-1:0]       out_src;
   logic [CNT_W-1:0]       stall_cnt;

   modport master (
      output in_valid, mode, sel, src_data, src_hit, src_ready, stall_in, flush,
      input  stall_req, out_valid, out_data, out_src, stall_cnt
   );

   modport slave (
      input  in_valid, mode, sel, src_data, src_hit, src_ready, stall_in, flush,
      output stall_req, out_valid, out_data, out_src, stall_cnt
   );

endinterface

// File: rtl/fwd_sel_pick.sv
// Source-index chooser: explicit select or highest-index forwarding hit (source 0 always hits).
module fwd_sel_pick
   import fwd_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int SEL_W = $clog2(N_SRC)
) (
   input  logic             mode_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [N_SRC-1:0] src_hit_i,
   output logic [SEL_W-1:0] idx_o
);

   always_comb begin
      idx_o = '0;
      if (mode_i == MODE_PRIORITY) begin
         // Ascending scan so the last (highest) hit wins; bit 0 is forced to count.
         for (int i = 0; i < N_SRC; i++) begin
            if (src_hit_i[i] || (i == 0)) idx_o = SEL_W'(i);
         end
      end else if (int'(sel_i) < N_SRC) begin
         idx_o = sel_i;
      end
   end

endmodule

// File: rtl/fwd_sel_stage.sv
// ID/EX operand register fed by an N-way select, with load-use interlock and stall counter.
module fwd_sel_stage
   import fwd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N_SRC = 4,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   fwd_sel_stage_if.slave  bus
);
   localparam int SEL_W = $clog2(N_SRC);

   logic [SEL_W-1:0] idx;
   logic [WIDTH-1:0] pick_data;
   logic             pick_ready;
   logic             stall_req;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] src_q, src_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   fwd_sel_pick #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_pick (
      .mode_i    (bus.mode),
      .sel_i     (bus.sel),
      .src_hit_i (bus.src_hit),
      .idx_o     (idx)
   );

   // One-hot style mux so unselected source bits (even X) never reach the outputs.
   always_comb begin
      pick_data  = '0;
      pick_ready = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (idx == SEL_W'(i)) begin
            pick_data  = bus.src_data[slice_off(i, WIDTH) +: WIDTH];
            pick_ready = bus.src_ready[i];
         end
      end
   end

   assign stall_req = bus.in_valid & ~pick_ready & ~bus.flush;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      if (bus.flush) begin
         valid_d = 1'b0;
         data_d  = '0;
         src_d   = '0;
      end else if (bus.stall_in) begin
         valid_d = valid_q;
      end else if (stall_req) begin
         valid_d = 1'b0;
      end else begin
         valid_d = bus.in_valid;
         if (bus.in_valid) begin
            data_d = pick_data;
            src_d  = idx;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_req && !bus.stall_in && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   // ID -> EX register boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.stall_req = stall_req;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;
   assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_sel_stage.sv
// Directed bench for fwd_sel_stage: 4-source instance plus a 3-source instance for out-of-range select.
module tb_fwd_sel_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fwd_sel_stage_if #(.WIDTH(32), .N_SRC(4), .CNT_W(8)) bus4 ();
   fwd_sel_stage_if #(.WIDTH(32), .N_SRC(3), .CNT_W(8)) bus3 ();

   fwd_sel_stage #(.WIDTH(32), .N_SRC(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   fwd_sel_stage #(.WIDTH(32), .N_SRC(3), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus4.in_valid = 1'b0; bus4.mode = 1'b0; bus4.sel = 2'd0;
      bus4.src_hit = 4'b0000; bus4.src_ready = 4'b1111; bus4.stall_in = 1'b0; bus4.flush = 1'b0;
      bus4.src_data = {32'h33330D03, 32'h22220C02, 32'h11110B01, 32'h00000A00};
      bus3.in_valid = 1'b0; bus3.mode = 1'b0; bus3.sel = 2'd0;
      bus3.src_hit = 3'b000; bus3.src_ready = 3'b111; bus3.stall_in = 1'b0; bus3.flush = 1'b0;
      bus3.src_data = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
   endtask

   task automatic test_reset();
      n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus4.out_valid); end
      n_checks++; if (bus4.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", bus4.out_data); end
      n_checks++; if (bus4.stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus4.stall_cnt); end
      rst_n = 1'b1;
      tick();
      // five interlock cycles, then load 0x12345678 from source 3
      bus4.in_valid = 1'b1; bus4.mode = 1'b1; bus4.src_hit = 4'b1000; bus4.src_ready = 4'b0111;
      repeat (5) tick();
      bus4.src_ready = 4'b1111;
      bus4.src_data = {32'h12345678, 32'h22220C02, 32'h11110B01, 32'h00000A00};
      tick();
      n_checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h12345678) begin n_fail++; $display("FAIL pre_reset_load: got valid %0b data %h expected 1 12345678", bus4.out_valid, bus4.out_data); end
      n_checks++; if (bus4.stall_cnt !== 8'd5) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d expected 5", bus4.stall_cnt); end
      idle();
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_src !== 2'd0) begin n_fail++; $display("FAIL async_reset_regs: got valid %0b data %h src %0d expected 0 0 0", bus4.out_valid, bus4.out_data, bus4.out_src); end
      n_checks++; if (bus4.stall_cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d expected 0", bus4.stall_cnt); end
      #1 rst_n = 1'b1;
      bus4.in_valid = 1'b1; bus4.mode = 1'b0; bus4.sel = 2'd1;
      tick();
      n_checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h11110B01 || bus4.out_src !== 2'd1) begin n_fail++; $display("FAIL post_reset_load: got valid %0b data %h src %0d expected 1 11110b01 1", bus4.out_valid, bus4.out_data, bus4.out_src); end
      idle();
   endtask

   task automatic test_explicit();
      bus4.in_valid = 1'b1; bus4.mode = 1'b0; bus4.sel = 2'd2;
      bus4.src_data = {32'h33330D03, 32'hDEADBEEF, 32'h11110B01, 32'h00000A00};
      bus3.in_valid = 1'b1; bus3.mode = 1'b0; bus3.sel = 2'd3;
      tick();
      n_checks++; if (bus4.out_data !== 32'hDEADBEEF || bus4.out_src !== 2'd2 || bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL explicit_sel2: got data %h src %0d valid %0b expected deadbeef 2 1", bus4.out_data, bus4.out_src, bus4.out_valid); end
      n_checks++; if (bus3.out_data !== 32'hA0A0A0A0 || bus3.out_src !== 2'd0 || bus3.out_valid !== 1'b1) begin n_fail++; $display("FAIL explicit_oob: got data %h src %0d valid %0b expected a0a0a0a0 0 1", bus3.out_data, bus3.out_src, bus3.out_valid); end
      bus3.sel = 2'd2;
      bus4.in_valid = 1'b0; bus4.sel = 2'd3;
      tick();
      n_checks++; if (bus3.out_data !== 32'hC2C2C2C2 || bus3.out_src !== 2'd2) begin n_fail++; $display("FAIL explicit_n3_sel2: got data %h src %0d expected c2c2c2c2 2", bus3.out_data, bus3.out_src); end
      n_checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'hDEADBEEF || bus4.out_src !== 2'd2) begin n_fail++; $display("FAIL idle_hold: got valid %0b data %h src %0d expected 0 deadbeef 2", bus4.out_valid, bus4.out_data, bus4.out_src); end
      idle();
   endtask

   task automatic test_priority();
      bus4.in_valid = 1'b1; bus4.mode = 1'b1; bus4.sel = 2'd1; bus4.src_hit = 4'b0110;
      tick();
      n_checks++; if (bus4.out_src !== 2'd2 || bus4.out_data !== 32'h22220C02) begin n_fail++; $display("FAIL prio_0110: got src %0d data %h expected 2 22220c02", bus4.out_src, bus4.out_data); end
      bus4.src_hit = 4'b1010;
      tick();
      n_checks++; if (bus4.out_src !== 2'd3 || bus4.out_data !== 32'h33330D03) begin n_fail++; $display("FAIL prio_1010: got src %0d data %h expected 3 33330d03", bus4.out_src, bus4.out_data); end
      bus4.src_hit = 4'b0000;
      tick();
      n_checks++; if (bus4.out_src !== 2'd0 || bus4.out_data !== 32'h00000A00 || bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_none: got src %0d data %h valid %0b expected 0 00000a00 1", bus4.out_src, bus4.out_data, bus4.out_valid); end
      idle();
   endtask

   task automatic test_interlock();
      bus4.in_valid = 1'b1; bus4.mode = 1'b1; bus4.src_hit = 4'b1000; bus4.src_ready = 4'b0111;
      bus4.src_data = {32'hBAD0BAD0, 32'h22220C02, 32'h11110B01, 32'h00000A00};
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++; if (bus4.stall_req !== 1'b1) begin n_fail++; $display("FAIL interlock_req[%0d]: got %0b expected 1", c, bus4.stall_req); end
         tick();
         n_checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h00000A00) begin n_fail++; $display("FAIL interlock_bubble[%0d]: got valid %0b data %h expected 0 00000a00", c, bus4.out_valid, bus4.out_data); end
      end
      bus4.src_ready = 4'b1111;
      bus4.src_data = {32'hCAFE0001, 32'h22220C02, 32'h11110B01, 32'h00000A00};
      #1;
      n_checks++; if (bus4.stall_req !== 1'b0) begin n_fail++; $display("FAIL interlock_release_req: got %0b expected 0", bus4.stall_req); end
      tick();
      n_checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'hCAFE0001 || bus4.out_src !== 2'd3) begin n_fail++; $display("FAIL interlock_resume: got valid %0b data %h src %0d expected 1 cafe0001 3", bus4.out_valid, bus4.out_data, bus4.out_src); end
      n_checks++; if (bus4.stall_cnt !== 8'd2) begin n_fail++; $display("FAIL interlock_cnt: got %0d expected 2", bus4.stall_cnt); end
      // flush while the chosen source is not ready: no request, no count
      bus4.src_ready = 4'b0111; bus4.flush = 1'b1;
      #1;
      n_checks++; if (bus4.stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_masks_req: got %0b expected 0", bus4.stall_req); end
      tick();
      n_checks++; if (bus4.stall_cnt !== 8'd2 || bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0) begin n_fail++; $display("FAIL flush_notready: got cnt %0d valid %0b data %h expected 2 0 0", bus4.stall_cnt, bus4.out_valid, bus4.out_data); end
      // mode change mid-stall re-picks the source
      bus4.flush = 1'b0;
      bus4.src_data = {32'hBAD0BAD0, 32'h22220C02, 32'h5555AAAA, 32'h00000A00};
      tick();
      bus4.mode = 1'b0; bus4.sel = 2'd1;
      #1;
      n_checks++; if (bus4.stall_req !== 1'b0) begin n_fail++; $display("FAIL mode_switch_req: got %0b expected 0", bus4.stall_req); end
      tick();
      n_checks++; if (bus4.out_src !== 2'd1 || bus4.out_data !== 32'h5555AAAA || bus4.out_valid !== 1'b1 || bus4.stall_cnt !== 8'd3) begin n_fail++; $display("FAIL mode_switch: got src %0d data %h valid %0b cnt %0d expected 1 5555aaaa 1 3", bus4.out_src, bus4.out_data, bus4.out_valid, bus4.stall_cnt); end
      idle();
   endtask

   task automatic test_control();
      bus4.in_valid = 1'b1; bus4.sel = 2'd2;
      bus4.src_data = {32'h33330003, 32'h22220002, 32'h11110001, 32'h00000000};
      tick();
      bus4.flush = 1'b1; bus4.stall_in = 1'b1;
      tick();
      n_checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_src !== 2'd0) begin n_fail++; $display("FAIL flush_over_stall: got valid %0b data %h src %0d expected 0 0 0", bus4.out_valid, bus4.out_data, bus4.out_src); end
      bus4.flush = 1'b0; bus4.stall_in = 1'b0; bus4.sel = 2'd3;
      tick();
      bus4.stall_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus4.sel = 2'(c);
         bus4.src_data = {32'hF0F00000 + c, 32'hE0E00000 + c, 32'hD0D00000 + c, 32'hC0C00000 + c};
         tick();
         n_checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h33330003 || bus4.out_src !== 2'd3) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid %0b data %h src %0d expected 1 33330003 3", c, bus4.out_valid, bus4.out_data, bus4.out_src); end
      end
      // interlock while downstream is stalled: request visible, but no count and no bubble
      bus4.mode = 1'b1; bus4.src_hit = 4'b1000; bus4.src_ready = 4'b0111;
      #1;
      n_checks++; if (bus4.stall_req !== 1'b1) begin n_fail++; $display("FAIL stalled_interlock_req: got %0b expected 1", bus4.stall_req); end
      repeat (2) tick();
      n_checks++; if (bus4.stall_cnt !== 8'd3 || bus4.out_valid !== 1'b1 || bus4.out_data !== 32'h33330003) begin n_fail++; $display("FAIL stalled_interlock: got cnt %0d valid %0b data %h expected 3 1 33330003", bus4.stall_cnt, bus4.out_valid, bus4.out_data); end
      idle();
   endtask

   task automatic test_saturation();
      bus4.in_valid = 1'b1; bus4.mode = 1'b1; bus4.src_hit = 4'b1000; bus4.src_ready = 4'b0111;
      repeat (251) tick();
      n_checks++; if (bus4.stall_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_pre: got %0d expected 254", bus4.stall_cnt); end
      tick();
      n_checks++; if (bus4.stall_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d expected 255", bus4.stall_cnt); end
      repeat (48) tick();
      n_checks++; if (bus4.stall_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", bus4.stall_cnt); end
      idle();
   endtask

   initial begin
      idle();
      #12;
      test_reset();
      test_explicit();
      test_priority();
      test_interlock();
      test_control();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
